// File: rtl/photon_count_uart_tx_if.sv
// rtl/photon_count_uart_tx_if.sv - sample strobe input and UART line/status outputs of photon_count_uart_tx
interface photon_count_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   data_in;
    logic          count_valid;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    modport master (
        output data_in, count_valid,
        input  tx, busy, fifo_level, overflow
    );

    modport slave (
        input  data_in, count_valid,
        output tx, busy, fifo_level, overflow
    );
endinterface

// File: rtl/photon_count_uart_tx.sv
// rtl/photon_count_uart_tx.sv - photon count FIFO + UART 8N1 packet sender; `PACKET_CHECKSUM_EN appends an XOR byte
module photon_count_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk50Mhz,
    input  logic                  rst,
    photon_count_uart_tx_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

`ifdef PACKET_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);
    localparam logic [7:0]    SYNC   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    // sample buffer: entries are {seq, count}
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [23:0]   pkt_q, pkt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [7:0]    byte_sel;

    always_comb begin
        fifo_full  = (level_q == FULL);
        fifo_empty = (level_q == '0);
        // a strobe on a full buffer is dropped even if a pop frees a slot this cycle
        push       = bus.count_valid && !fifo_full;
        pop        = (state_q == IDLE) && !fifo_empty;

        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        seq_d      = bus.count_valid ? seq_q + 8'd1 : seq_q;
        overflow_d = overflow_q | (bus.count_valid & fifo_full);
    end

    always_ff @(posedge clk50Mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {seq_q, bus.data_in};
        end
    end

    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        byte_sel = SYNC;
        case (idx_q)
            3'd0:    byte_sel = SYNC;
            3'd1:    byte_sel = pkt_q[23:16];
            3'd2:    byte_sel = pkt_q[15:8];
            3'd3:    byte_sel = pkt_q[7:0];
`ifdef PACKET_CHECKSUM_EN
            3'd4:    byte_sel = SYNC ^ pkt_q[23:16] ^ pkt_q[15:8] ^ pkt_q[7:0];
`endif
            default: byte_sel = SYNC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    pkt_d   = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_d    = byte_sel;
                cnt_d   = RELOAD;
                state_d = START;
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // line and busy are registered from the next state so they change on the state edge
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = sh_d[0];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_photon_count_uart_tx.sv
// tb/tb_photon_count_uart_tx.sv - randomized self-checking bench for photon_count_uart_tx
module tb_photon_count_uart_tx;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 12500000;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef PACKET_CHECKSUM_EN
    localparam int NB  = 5;
    localparam int PKT = 50 * DIV + 5;
`else
    localparam int NB  = 4;
    localparam int PKT = 40 * DIV + 4;
`endif

    logic clk50Mhz = 1'b0;
    logic rst = 1'b1;

    photon_count_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    photon_count_uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk50Mhz(clk50Mhz),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk50Mhz = ~clk50Mhz;

    int n_cmp = 0;
    int n_fail = 0;
    int framing_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    // reference: FIFO of {seq,data}; the sender takes one entry whenever it has been idle
    // for at least one cycle, then stays occupied for one full packet
    logic [23:0] m_fifo[$];
    logic [7:0]  m_seq = 8'd0;
    logic        m_ovf = 1'b0;
    int          m_cyc = 0;
    int          m_free = 0;

    initial begin
        int n0;
        logic [23:0] e;
        forever begin
            @(posedge clk50Mhz);
            m_cyc++;
            if (rst) begin
                m_fifo.delete();
                m_seq  = 8'd0;
                m_ovf  = 1'b0;
                m_free = 0;
            end else begin
                n0 = m_fifo.size();
                if (n0 != 0 && m_cyc >= m_free) begin
                    e = m_fifo.pop_front();
                    m_free = m_cyc + PKT + 1;
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(e[23:16]);
                    exp_q.push_back(e[15:8]);
                    exp_q.push_back(e[7:0]);
                    if (NB == 5) exp_q.push_back(8'hA5 ^ e[23:16] ^ e[15:8] ^ e[7:0]);
                end
                if (bus.count_valid) begin
                    if (n0 >= DEPTH) m_ovf = 1'b1;
                    else m_fifo.push_back({m_seq, bus.data_in});
                    m_seq = m_seq + 8'd1;
                end
            end
        end
    end

    // line receiver: detect start bit, sample each following bit one bit period apart
    initial begin
        int rc;
        int k;
        logic active;
        logic [7:0] sh;
        active = 1'b0;
        rc = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk50Mhz);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (bus.tx === 1'b0) begin
                    active = 1'b1;
                    rc = 0;
                end
            end else begin
                rc++;
                if (rc % DIV == 0) begin
                    k = rc / DIV;
                    if (k <= 8) begin
                        sh[k-1] = bus.tx;
                    end else begin
                        if (bus.tx !== 1'b1) framing_err++;
                        rx_q.push_back(sh);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        bus.count_valid = 1'b0;
        bus.data_in = 16'h0000;
        repeat (3) @(posedge clk50Mhz);
        #1 rst = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < (DEPTH + 2) * (PKT + 1) + 100; i++) begin
            @(negedge clk50Mhz);
            if (bus.busy === 1'b0 && bus.fifo_level === '0) begin
                repeat (3) @(negedge clk50Mhz);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk50Mhz);
        n_cmp++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_single();
        logic [7:0] ref_b [5];
        int lat;
        int hi;
        bit ok;
        ref_b = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h83};
        apply_reset();
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b1; bus.data_in = 16'h1234;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk50Mhz);
            lat++;
            if (lat == 1) begin
                #1 bus.count_valid = 1'b0;
            end
            @(negedge clk50Mhz);
            if (bus.tx === 1'b0) break;
        end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", lat); end
        hi = 2;
        for (int i = 0; i < 2 * PKT; i++) begin
            @(negedge clk50Mhz);
            if (bus.busy === 1'b1) hi++;
            else break;
        end
        n_cmp++; if (hi !== PKT) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", hi, PKT); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout expected idle"); end
        n_cmp++; if (rx_q.size() !== NB) begin n_fail++; $display("FAIL single_len: got %0d expected %0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== ref_b[i]) begin n_fail++; $display("FAIL single_byte%0d: got %02h expected %02h", i, rx_q[i], ref_b[i]); end
        end
    endtask

    task automatic test_push_pop();
        bit ok;
        apply_reset();
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b1; bus.data_in = 16'(($urandom));
        @(posedge clk50Mhz);
        #1 bus.data_in = 16'($urandom);
        @(negedge clk50Mhz);
        n_cmp++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL pp_level_before: got %0d expected 1", bus.fifo_level); end
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b0;
        @(negedge clk50Mhz);
        n_cmp++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL pp_level_same: got %0d expected 1", bus.fifo_level); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL pp_drain: got timeout expected idle"); end
        n_cmp++; if (rx_q.size() !== 2 * NB) begin n_fail++; $display("FAIL pp_len: got %0d expected %0d", rx_q.size(), 2 * NB); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pp_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
        for (int p = 0; p < 2 && p * NB + 1 < rx_q.size(); p++) begin
            n_cmp++; if (rx_q[p*NB+1] !== 8'(p)) begin n_fail++; $display("FAIL pp_seq%0d: got %02h expected %02h", p, rx_q[p*NB+1], 8'(p)); end
        end
    endtask

    task automatic test_overflow();
        int peak;
        bit ok;
        apply_reset();
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk50Mhz);
            #1 bus.count_valid = 1'b1; bus.data_in = 16'(i + 1);
            @(negedge clk50Mhz);
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
        end
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b0;
        repeat (3) begin
            @(negedge clk50Mhz);
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
        end
        n_cmp++; if (peak !== DEPTH) begin n_fail++; $display("FAIL ovf_peak: got %0d expected %0d", peak, DEPTH); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: got timeout expected idle"); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        n_cmp++; if (rx_q.size() !== 5 * NB) begin n_fail++; $display("FAIL ovf_len: got %0d expected %0d", rx_q.size(), 5 * NB); end
        for (int p = 0; p < 5 && p * NB + 3 < rx_q.size(); p++) begin
            n_cmp++; if (rx_q[p*NB+1] !== 8'(p)) begin n_fail++; $display("FAIL ovf_seq%0d: got %02h expected %02h", p, rx_q[p*NB+1], 8'(p)); end
            n_cmp++; if (rx_q[p*NB+3] !== 8'(p + 1)) begin n_fail++; $display("FAIL ovf_data%0d: got %02h expected %02h", p, rx_q[p*NB+3], 8'(p + 1)); end
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk50Mhz);
            #1 bus.count_valid = 1'b1; bus.data_in = 16'($urandom);
        end
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b0;
        t = 0;
        while (t < 50) begin
            @(negedge clk50Mhz);
            t++;
            if (bus.tx === 1'b0) break;
        end
        n_cmp++; if (t >= 50) begin n_fail++; $display("FAIL mid_start: got timeout expected start bit"); end
        repeat (11 * DIV + 3) @(posedge clk50Mhz);
        #1 rst = 1'b1;
        @(posedge clk50Mhz);
        #1 rst = 1'b0;
        @(negedge clk50Mhz);
        n_cmp++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: got %b expected 1", bus.tx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.fifo_level !== '0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b expected 0", bus.overflow); end
        rx_q.delete();
        exp_q.delete();
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b1; bus.data_in = 16'($urandom);
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b0;
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_drain: got timeout expected idle"); end
        n_cmp++; if (rx_q.size() !== NB) begin n_fail++; $display("FAIL mid_len: got %0d expected %0d", rx_q.size(), NB); end
        if (rx_q.size() > 1) begin
            n_cmp++; if (rx_q[1] !== 8'h00) begin n_fail++; $display("FAIL mid_seq: got %02h expected 00", rx_q[1]); end
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int gap;
        bit ok;
        apply_reset();
        for (int s = 0; s < 40; s++) begin
            @(posedge clk50Mhz);
            #1 bus.count_valid = 1'b1; bus.data_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) gap = $urandom_range(PKT, 2 * PKT);
            else gap = $urandom_range(0, PKT / 3);
            if (gap > 0) begin
                @(posedge clk50Mhz);
                #1 bus.count_valid = 1'b0;
                repeat (gap - 1) @(posedge clk50Mhz);
            end
        end
        @(posedge clk50Mhz);
        #1 bus.count_valid = 1'b0;
        @(negedge clk50Mhz);
        n_cmp++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow: got %b expected %b", bus.overflow, m_ovf); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rnd_drain: got timeout expected idle"); end
        n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        apply_reset();
        for (int s = 0; s < 257; s++) begin
            @(posedge clk50Mhz);
            #1 bus.count_valid = 1'b1; bus.data_in = 16'($urandom);
            @(posedge clk50Mhz);
            #1 bus.count_valid = 1'b0;
            repeat (198) @(posedge clk50Mhz);
        end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_drain: got timeout expected idle"); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b expected 0", bus.overflow); end
        n_cmp++; if (rx_q.size() !== 257 * NB) begin n_fail++; $display("FAIL wrap_len: got %0d expected %0d", rx_q.size(), 257 * NB); end
        for (int p = 0; p < 257 && p * NB + 1 < rx_q.size(); p++) begin
            n_cmp++; if (rx_q[p*NB+1] !== 8'(p)) begin n_fail++; $display("FAIL wrap_seq%0d: got %02h expected %02h", p, rx_q[p*NB+1], 8'(p)); end
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bus.count_valid = 1'b0;
        bus.data_in = 16'h0000;
        test_reset();
        test_single();
        test_push_pop();
        test_overflow();
        test_reset_mid();
        test_random();
        test_seq_wrap();
        n_cmp++; if (framing_err !== 0) begin n_fail++; $display("FAIL framing: got %0d expected 0", framing_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
